axi4lite_slave_regs: RTL and testbench
======================================

# axi4lite_slave_regs

AXI4-Lite slave register file that sits directly downstream of the AXI4-Lite master in `tt_um_axi4lite_top`, terminating the five channels the master drives. It holds four 8-bit registers: three read/write, one read-only identification register. Register contents are exported in parallel so the top level can route them to `uo_out`. Write and read paths are independent and may proceed concurrently.

## Interface
- `DATA_W`, 8, data width of every register and of WDATA/RDATA
- `ADDR_W`, 2, word address width; register index = address
- `ID_VALUE`, 8'hA5, constant returned by register 3
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `s_awaddr` in ADDR_W: write address
- `s_awvalid` in 1 / `s_awready` out 1: write-address handshake
- `s_wdata` in DATA_W: write data
- `s_wvalid` in 1 / `s_wready` out 1: write-data handshake
- `s_bresp` out 2: write response
- `s_bvalid` out 1 / `s_bready` in 1: write-response handshake
- `s_araddr` in ADDR_W: read address
- `s_arvalid` in 1 / `s_arready` out 1: read-address handshake
- `s_rdata` out DATA_W: read data
- `s_rresp` out 2: read response
- `s_rvalid` out 1 / `s_rready` in 1: read-data handshake
- `reg_out` out 4*DATA_W: {reg3, reg2, reg1, reg0}, registered

## Operation
- Registers 0–2: R/W, reset 8'h00. Register 3: read-only, always ID_VALUE.
- Write path states: IDLE, HAVE_AW, HAVE_W, RESP. AW and W are accepted independently and in either order; each is latched once and held.
  - IDLE → HAVE_AW on AW handshake only; → HAVE_W on W only; both in same cycle → commit.
  - HAVE_AW/HAVE_W → commit on the missing handshake.
  - Commit: write register (addr 0–2), BRESP = OKAY 2'b00; addr 3: data discarded, BRESP = SLVERR 2'b10. Enter RESP with bvalid=1.
  - RESP → IDLE on bvalid && bready.
- Read path states: IDLE, RESP. AR handshake loads rdata (current register value) and RRESP (always OKAY) and enters RESP. RESP → IDLE on rvalid && rready.
- `s_bresp`, `s_rdata` and `s_rresp` remain stable while their valid is high.

## Timing
- Reset values: awready=1, wready=1, bvalid=0, bresp=00, arready=1, rvalid=0, rdata=00, rresp=00, reg_out=0.
- `s_awready` = 1 only in IDLE or HAVE_W. `s_wready` = 1 only in IDLE or HAVE_AW. Both are 0 in RESP, so there is no new write until B completes.
- `s_arready` = 1 only when read path is IDLE. Maximum throughput is one read per 2 cycles.
- Write latency: commit on the edge completing the last of AW/W. `reg_out` and `s_bvalid` both update on that edge.
- Read latency: `s_rvalid` and `s_rdata` are valid after the AR handshake edge.
- Simultaneous read AR handshake and write commit to the same register: read returns the pre-write value.
- bready/rready held high: response retires on the first edge it is visible, and ready returns the next cycle.
- Valid deasserted by the master before handshake: no state change. A latched half of a write is never dropped.
- Reset mid-transaction: all state returns to reset values immediately and pending responses are lost.

## Structure
- Shared package `axi4lite_pkg` holds:
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - register index constants REG_CTRL0..REG_ID (0..3);
  - write-path state encoding and read-path state encoding.
- No sub-module. The write and read FSMs plus the register array fit in one module.

## Test plan
- Reset asserted mid-run → all outputs match the reset values above, and reg_out=32'h0 the same cycle.
- AW(addr 1) and W(8'hAA) in same cycle, bready=1 → reg_out[15:8]=AA on next edge, bresp=00, bvalid for one cycle.
- W(8'h3C) three cycles before AW(addr 2) → wready low after W accepted, reg2=3C only after AW, bresp=00.
- Write 8'hFF to addr 3 → bresp=10, reg_out[31:24] stays A5; read addr 3 → rdata=A5, rresp=00.
- Read addr 1 with rready low for 4 cycles → rvalid and rdata=AA held stable, arready=0 throughout, release after rready.
- Write addr 0 = 8'h55 committing on the same edge as AR addr 0 → rdata=00; following read → 55.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, register map indices and
// the state encodings of the slave's independent write and read paths.
package axi4lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_CTRL0 = 2'd0;
    localparam logic [1:0] REG_CTRL1 = 2'd1;
    localparam logic [1:0] REG_CTRL2 = 2'd2;
    localparam logic [1:0] REG_ID    = 2'd3;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/axi4lite_slave_regs_if.sv
// The five AXI4-Lite channels between the master and the register-file slave.
interface axi4lite_slave_regs_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) ();
    import axi4lite_pkg::*;

    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [DATA_W-1:0] s_wdata;
    logic              s_wvalid;
    logic              s_wready;
    resp_t             s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    resp_t             s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave with three R/W registers and a read-only ID register;
// write and read paths are independent FSMs that may run concurrently.
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               ADDR_W   = 2,
    parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4lite_slave_regs_if.slave  bus,
    output logic [4*DATA_W-1:0]   reg_out
);

    wr_state_t         wr_state, wr_next;
    rd_state_t         rd_state, rd_next;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] regs [3];
    logic [DATA_W-1:0] id_q;
    logic              aw_hs, w_hs, ar_hs, wr_commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data, rd_value;

    assign bus.s_awready = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_W);
    assign bus.s_wready  = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_AW);
    assign bus.s_bvalid  = (wr_state == WR_RESP);
    assign bus.s_arready = (rd_state == RD_IDLE);
    assign bus.s_rvalid  = (rd_state == RD_RESP);

    assign aw_hs = bus.s_awvalid && bus.s_awready;
    assign w_hs  = bus.s_wvalid  && bus.s_wready;
    assign ar_hs = bus.s_arvalid && bus.s_arready;

    // The half that arrived first comes from its latch, the other straight off the bus.
    assign wr_addr = (wr_state == WR_HAVE_AW) ? awaddr_q : bus.s_awaddr;
    assign wr_data = (wr_state == WR_HAVE_W)  ? wdata_q  : bus.s_wdata;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_next   = wr_state;
        wr_commit = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                    wr_next   = WR_RESP;
                end else if (aw_hs) begin
                    wr_next = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: if (w_hs) begin
                wr_commit = 1'b1;
                wr_next   = WR_RESP;
            end
            WR_HAVE_W: if (aw_hs) begin
                wr_commit = 1'b1;
                wr_next   = WR_RESP;
            end
            WR_RESP: if (bus.s_bready) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)        rd_next = RD_RESP;
            RD_RESP: if (bus.s_rready) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_value = '0;
        case (bus.s_araddr)
            REG_CTRL0: rd_value = regs[0];
            REG_CTRL1: rd_value = regs[1];
            REG_CTRL2: rd_value = regs[2];
            REG_ID:    rd_value = ID_VALUE;
            default:   rd_value = '0;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values,
    // which is also what makes a same-edge read return the pre-write register value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state    <= WR_IDLE;
            rd_state    <= RD_IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            bus.s_bresp <= RESP_OKAY;
            bus.s_rdata <= '0;
            bus.s_rresp <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            if (aw_hs) awaddr_q <= bus.s_awaddr;
            if (w_hs)  wdata_q  <= bus.s_wdata;
            if (wr_commit)
                bus.s_bresp <= (wr_addr == REG_ID) ? RESP_SLVERR : RESP_OKAY;
            if (ar_hs) begin
                bus.s_rdata <= rd_value;
                bus.s_rresp <= RESP_OKAY;
            end
        end
    end

    // NOTE: the register array is only three words of flops, so it is reset like any
    // other state; reg_out must read zero while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
            id_q <= '0;
        end else begin
            id_q <= ID_VALUE;
            if (wr_commit) begin
                case (wr_addr)
                    REG_CTRL0: regs[0] <= wr_data;
                    REG_CTRL1: regs[1] <= wr_data;
                    REG_CTRL2: regs[2] <= wr_data;
                    default:   ;
                endcase
            end
        end
    end

    assign reg_out = {id_q, regs[2], regs[1], regs[0]};

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: hand-computed expectations for
// write ordering, SLVERR on the ID register, read back-pressure and reset.
module tb_axi4lite_slave_regs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] reg_out;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi4lite_slave_regs_if bus ();

    axi4lite_slave_regs dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .reg_out (reg_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " awready"}, 32'(bus.s_awready), 32'd1);
        check({tag, " wready"},  32'(bus.s_wready),  32'd1);
        check({tag, " bvalid"},  32'(bus.s_bvalid),  32'd0);
        check({tag, " bresp"},   32'(bus.s_bresp),   32'd0);
        check({tag, " arready"}, 32'(bus.s_arready), 32'd1);
        check({tag, " rvalid"},  32'(bus.s_rvalid),  32'd0);
        check({tag, " rdata"},   32'(bus.s_rdata),   32'd0);
        check({tag, " rresp"},   32'(bus.s_rresp),   32'd0);
        check({tag, " reg_out"}, reg_out,            32'h0);
    endtask

    initial begin
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata  = '0; bus.s_wvalid  = 1'b0;
        bus.s_bready = 1'b0;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0;

        step();
        step();
        check_reset_outputs("por");
        rst = 1'b0;
        step();
        check("id after reset", reg_out, 32'hA500_0000);

        // AW and W together to reg1
        bus.s_awaddr = 2'd1; bus.s_awvalid = 1'b1;
        bus.s_wdata  = 8'hAA; bus.s_wvalid = 1'b1;
        bus.s_bready = 1'b1;
        step();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("t1 reg_out", reg_out, 32'hA500_AA00);
        check("t1 bvalid", 32'(bus.s_bvalid), 32'd1);
        check("t1 bresp", 32'(bus.s_bresp), 32'd0);
        check("t1 awready busy", 32'(bus.s_awready), 32'd0);
        step();
        check("t1 bvalid retired", 32'(bus.s_bvalid), 32'd0);
        check("t1 awready back", 32'(bus.s_awready), 32'd1);

        // W first, AW three cycles later, to reg2
        bus.s_wdata = 8'h3C; bus.s_wvalid = 1'b1;
        step();
        bus.s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2 wready held low", 32'(bus.s_wready), 32'd0);
            check("t2 awready", 32'(bus.s_awready), 32'd1);
            check("t2 reg2 not yet", reg_out, 32'hA500_AA00);
            if (i == 2) begin
                bus.s_awaddr = 2'd2; bus.s_awvalid = 1'b1;
            end
            step();
        end
        bus.s_awvalid = 1'b0;
        check("t2 reg_out", reg_out, 32'hA53C_AA00);
        check("t2 bvalid", 32'(bus.s_bvalid), 32'd1);
        check("t2 bresp", 32'(bus.s_bresp), 32'd0);
        step();
        check("t2 bvalid retired", 32'(bus.s_bvalid), 32'd0);

        // write to the read-only ID register, then read it
        bus.s_awaddr = 2'd3; bus.s_awvalid = 1'b1;
        bus.s_wdata  = 8'hFF; bus.s_wvalid = 1'b1;
        step();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("t3 bresp slverr", 32'(bus.s_bresp), 32'd2);
        check("t3 bvalid", 32'(bus.s_bvalid), 32'd1);
        check("t3 reg_out id kept", reg_out, 32'hA53C_AA00);
        step();
        bus.s_araddr = 2'd3; bus.s_arvalid = 1'b1; bus.s_rready = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        check("t3 rvalid", 32'(bus.s_rvalid), 32'd1);
        check("t3 rdata id", 32'(bus.s_rdata), 32'h0000_00A5);
        check("t3 rresp", 32'(bus.s_rresp), 32'd0);
        check("t3 arready busy", 32'(bus.s_arready), 32'd0);
        step();
        check("t3 rvalid retired", 32'(bus.s_rvalid), 32'd0);
        check("t3 arready back", 32'(bus.s_arready), 32'd1);

        // read reg1 with rready low for four cycles
        bus.s_rready = 1'b0;
        bus.s_araddr = 2'd1; bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4 rvalid held", 32'(bus.s_rvalid), 32'd1);
            check("t4 rdata held", 32'(bus.s_rdata), 32'h0000_00AA);
            check("t4 arready low", 32'(bus.s_arready), 32'd0);
            if (i == 3) bus.s_rready = 1'b1;
            step();
        end
        check("t4 rvalid released", 32'(bus.s_rvalid), 32'd0);
        check("t4 arready released", 32'(bus.s_arready), 32'd1);

        // write reg0 and read reg0 on the same edge
        bus.s_rready = 1'b0;
        bus.s_awaddr = 2'd0; bus.s_awvalid = 1'b1;
        bus.s_wdata  = 8'h55; bus.s_wvalid = 1'b1;
        bus.s_araddr = 2'd0; bus.s_arvalid = 1'b1;
        step();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        check("t5 rdata pre-write", 32'(bus.s_rdata), 32'h0);
        check("t5 reg_out", reg_out, 32'hA53C_AA55);
        bus.s_rready = 1'b1;
        step();
        bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        check("t5 rdata post-write", 32'(bus.s_rdata), 32'h0000_0055);
        step();

        // AW first then W, with bready withheld
        bus.s_bready = 1'b0;
        bus.s_awaddr = 2'd1; bus.s_awvalid = 1'b1;
        step();
        bus.s_awvalid = 1'b0;
        check("t6 awready after aw", 32'(bus.s_awready), 32'd0);
        check("t6 wready after aw", 32'(bus.s_wready), 32'd1);
        check("t6 no commit yet", reg_out, 32'hA53C_AA55);
        bus.s_awaddr = 2'd2;
        bus.s_wdata = 8'h12; bus.s_wvalid = 1'b1;
        step();
        bus.s_wvalid = 1'b0;
        check("t6 reg_out latched addr", reg_out, 32'hA53C_1255);
        check("t6 bvalid", 32'(bus.s_bvalid), 32'd1);
        step();
        check("t6 bvalid held", 32'(bus.s_bvalid), 32'd1);
        check("t6 wready held low", 32'(bus.s_wready), 32'd0);
        bus.s_bready = 1'b1;
        step();
        check("t6 bvalid retired", 32'(bus.s_bvalid), 32'd0);

        // reset while a write half and a read response are pending
        bus.s_rready = 1'b0;
        bus.s_awaddr = 2'd3; bus.s_awvalid = 1'b1; bus.s_wdata = 8'h77; bus.s_wvalid = 1'b1;
        bus.s_bready = 1'b0;
        bus.s_araddr = 2'd2; bus.s_arvalid = 1'b1;
        step();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        check("t7 bresp before reset", 32'(bus.s_bresp), 32'd2);
        check("t7 rdata before reset", 32'(bus.s_rdata), 32'h0000_003C);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid reset");
        step();
        rst = 1'b0;
        step();
        check("t7 reg_out after reset", reg_out, 32'hA500_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
